// File: rtl/life_grid_engine.sv
// life_grid_engine: Game of Life engine with cell loads, per-step evaluation and ready/valid pixel output.
// Build option: define LIFE_TORUS_EN for a toroidal (wrap-around) grid; the default build is bounded.
module life_grid_engine #(
  parameter int         GRID_W       = 16,
  parameter int         GRID_H       = 16,
  parameter int         COORD_W      = 8,
  parameter logic [2:0] ALIVE_COLOUR = 3'b111,
  parameter logic [2:0] DEAD_COLOUR  = 3'b000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic               load_alive,
  input  logic               step,
  input  logic               clear,
  output logic               busy,
  output logic               done,
  output logic               plot,
  input  logic               plot_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [2:0]         out_colour,
  output logic [15:0]        generation
);

  // state       | meaning
  // S_IDLE      | waiting for clear / load / step
  // S_LOAD_PLOT | holding the pixel of a loaded cell until accepted
  // S_EVAL      | one cell per cycle: neighbours of cur -> nxt
  // S_DRAW      | scan, plot and commit cells where nxt differs from cur
  // S_CLEAR     | scan, plot and kill every live cell

  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W:0]   X_LIM  = (COORD_W + 1)'(GRID_W);
  localparam logic [COORD_W:0]   Y_LIM  = (COORD_W + 1)'(GRID_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_PLOT,
    S_EVAL,
    S_DRAW,
    S_CLEAR
  } state_t;

  state_t                        state_q, state_d;
  logic [GRID_H-1:0][GRID_W-1:0] cur_q, cur_d;
  logic [GRID_H-1:0][GRID_W-1:0] nxt_q, nxt_d;
  logic [COORD_W-1:0]            scan_x_q, scan_x_d;
  logic [COORD_W-1:0]            scan_y_q, scan_y_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          plot_q, plot_d;
  logic [COORD_W-1:0]            out_x_q, out_x_d;
  logic [COORD_W-1:0]            out_y_q, out_y_d;
  logic [2:0]                    out_colour_q, out_colour_d;
  logic [15:0]                   gen_q, gen_d;

  logic [XW-1:0]      sx, lx;
  logic [YW-1:0]      sy, ly;
  logic [COORD_W-1:0] adv_x, adv_y;
  logic               scan_last, load_in_range, scan_adv;
  logic               cell_cur, cell_nxt, cell_next_gen;
  logic [3:0]         nbr_cnt;
  int                 nx, ny;

  assign sx = scan_x_q[XW-1:0];
  assign sy = scan_y_q[YW-1:0];
  assign lx = load_x[XW-1:0];
  assign ly = load_y[YW-1:0];

  assign scan_last     = (scan_x_q == X_LAST) && (scan_y_q == Y_LAST);
  assign adv_x         = (scan_x_q == X_LAST) ? '0 : scan_x_q + 1'b1;
  assign adv_y         = (scan_x_q != X_LAST) ? scan_y_q :
                         (scan_y_q == Y_LAST) ? '0 : scan_y_q + 1'b1;
  assign load_in_range = ({1'b0, load_x} < X_LIM) && ({1'b0, load_y} < Y_LIM);

  assign cell_cur = cur_q[sy][sx];
  assign cell_nxt = nxt_q[sy][sx];

  // Neighbour count of the scan cell, read from cur only.
  always_comb begin
    nbr_cnt = '0;
    nx      = 0;
    ny      = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(scan_x_q) + dx;
        ny = int'(scan_y_q) + dy;
        if (dx != 0 || dy != 0) begin
`ifdef LIFE_TORUS_EN
          if (nx < 0) nx = GRID_W - 1;
          else if (nx >= GRID_W) nx = 0;
          if (ny < 0) ny = GRID_H - 1;
          else if (ny >= GRID_H) ny = 0;
          nbr_cnt = nbr_cnt + {3'b000, cur_q[ny[YW-1:0]][nx[XW-1:0]]};
`else
          if (nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H)
            nbr_cnt = nbr_cnt + {3'b000, cur_q[ny[YW-1:0]][nx[XW-1:0]]};
`endif
        end
      end
    end
  end

  assign cell_next_gen = (nbr_cnt == 4'd3) || (cell_cur && nbr_cnt == 4'd2);

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    nxt_d        = nxt_q;
    scan_x_d     = scan_x_q;
    scan_y_d     = scan_y_q;
    plot_d       = plot_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_colour_d = out_colour_q;
    done_d       = 1'b0;
    gen_d        = gen_q;
    scan_adv     = 1'b0;

    case (state_q)
      S_IDLE: begin
        scan_x_d = '0;
        scan_y_d = '0;
        if (clear) begin
          state_d = S_CLEAR;
        end else if (load) begin
          if (load_in_range) begin
            cur_d[ly][lx] = load_alive;
            plot_d        = 1'b1;
            out_x_d       = load_x;
            out_y_d       = load_y;
            out_colour_d  = load_alive ? ALIVE_COLOUR : DEAD_COLOUR;
            state_d       = S_LOAD_PLOT;
          end
        end else if (step) begin
          state_d = S_EVAL;
        end
      end

      S_LOAD_PLOT: begin
        if (plot_ready) begin
          plot_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_EVAL: begin
        nxt_d[sy][sx] = cell_next_gen;
        scan_x_d      = adv_x;
        scan_y_d      = adv_y;
        if (scan_last) state_d = S_DRAW;
      end

      // DRAW and CLEAR share the scan: a cell needing a pixel costs one extra
      // cycle (plus stalls) and is committed only once the pixel is accepted.
      S_DRAW, S_CLEAR: begin
        if (plot_q) begin
          if (plot_ready) begin
            cur_d[sy][sx] = (state_q == S_DRAW) ? cell_nxt : 1'b0;
            plot_d        = 1'b0;
            scan_adv      = 1'b1;
          end
        end else if ((state_q == S_DRAW) ? (cell_nxt != cell_cur) : cell_cur) begin
          plot_d       = 1'b1;
          out_x_d      = scan_x_q;
          out_y_d      = scan_y_q;
          out_colour_d = (state_q == S_DRAW && cell_nxt) ? ALIVE_COLOUR : DEAD_COLOUR;
        end else begin
          scan_adv = 1'b1;
        end
        if (scan_adv) begin
          scan_x_d = adv_x;
          scan_y_d = adv_y;
          if (scan_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            gen_d   = (state_q == S_DRAW) ? gen_q + 16'd1 : 16'd0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      nxt_q        <= '0;
      scan_x_q     <= '0;
      scan_y_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      plot_q       <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_colour_q <= '0;
      gen_q        <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      nxt_q        <= nxt_d;
      scan_x_q     <= scan_x_d;
      scan_y_q     <= scan_y_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      plot_q       <= plot_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_colour_q <= out_colour_d;
      gen_q        <= gen_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign plot       = plot_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_colour = out_colour_q;
  assign generation = gen_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine on a 5x5 grid; torus expectations follow LIFE_TORUS_EN.
module tb_life_grid_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0, step = 1'b0, clear = 1'b0, load_alive = 1'b0;
  logic [7:0]  load_x = '0, load_y = '0;
  logic        plot_ready = 1'b1;
  logic        busy, done, plot;
  logic [7:0]  out_x, out_y;
  logic [2:0]  out_colour;
  logic [15:0] generation;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int done_at = -1;
  int ndone = 0;
  logic [18:0] plots[$];
  int          holds[$];

  life_grid_engine #(.GRID_W(5), .GRID_H(5), .COORD_W(8)) dut (
    .clock(clock), .reset(reset), .load(load), .load_x(load_x), .load_y(load_y),
    .load_alive(load_alive), .step(step), .clear(clear), .busy(busy), .done(done),
    .plot(plot), .plot_ready(plot_ready), .out_x(out_x), .out_y(out_y),
    .out_colour(out_colour), .generation(generation)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic logic [18:0] enc(input int x, input int y, input int c);
    return {x[7:0], y[7:0], c[2:0]};
  endfunction

  // Runs up to budget cycles, sampling at negedge, recording accepted pixels.
  task automatic collect(input int budget, input int stall, input bit stop_on_done, input int poke);
    int hold = 0;
    logic [18:0] held = '0;
    plots.delete(); holds.delete();
    ndone = 0; done_at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      load = 1'b0; step = 1'b0; clear = 1'b0;
      if (i == poke) step = 1'b1;
      if (plot === 1'b1) begin
        hold++;
        if (hold > 1) begin
          checks++;
          if ({out_x, out_y, out_colour} !== held) begin
            errors++;
            $display("FAIL plot_stable got=%h exp=%h", {out_x, out_y, out_colour}, held);
          end
        end
        held = {out_x, out_y, out_colour};
        plot_ready = (stall == 0) || (hold > stall);
        if (plot_ready) begin
          plots.push_back(held);
          holds.push_back(hold);
          hold = 0;
        end
      end else begin
        if (hold > 0) begin
          checks++; errors++;
          $display("FAIL plot_dropped got plot=%b exp plot=1 after %0d cycles", plot, hold);
          hold = 0;
        end
        plot_ready = (stall == 0);
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = cyc;
        if (stop_on_done) break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    @(negedge clock); reset = 1'b0; plot_ready = 1'b1;
  endtask

  task automatic do_load(input int x, input int y, input bit alive);
    @(negedge clock);
    load = 1'b1; load_x = 8'(x); load_y = 8'(y); load_alive = alive; plot_ready = 1'b1;
    @(negedge clock);
    load = 1'b0;
    checks++;
    if (!(plot === 1'b1 && busy === 1'b1 && {out_x, out_y, out_colour} === enc(x, y, alive ? 7 : 0))) begin
      errors++;
      $display("FAIL load_plot got plot=%b busy=%b pix=%h exp plot=1 busy=1 pix=%h",
               plot, busy, {out_x, out_y, out_colour}, enc(x, y, alive ? 7 : 0));
    end
    @(negedge clock);
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_release got plot=%b busy=%b exp 0 0", plot, busy);
    end
  endtask

  task automatic load_blinker_h();
    do_load(1, 2, 1'b1); do_load(2, 2, 1'b1); do_load(3, 2, 1'b1);
  endtask

  task automatic start_step();
    @(negedge clock); step = 1'b1; plot_ready = 1'b1; t0 = cyc;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, plot} !== 3'b000 || {out_x, out_y, out_colour} !== 19'd0 || generation !== 16'd0) begin
      errors++;
      $display("FAIL reset_values got busy=%b done=%b plot=%b pix=%h gen=%0d exp all 0",
               busy, done, plot, {out_x, out_y, out_colour}, generation);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || plot !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b plot=%b exp 0 0", busy, plot);
    end
  endtask

  task automatic test_blinker();
    logic [18:0] exp_q[$];
    load_blinker_h();
    exp_q.push_back(enc(2, 1, 7)); exp_q.push_back(enc(1, 2, 0));
    exp_q.push_back(enc(3, 2, 0)); exp_q.push_back(enc(2, 3, 7));
    start_step(); collect(300, 0, 1'b1, -1);
    checks++;
    if (plots.size() != exp_q.size()) begin
      errors++; $display("FAIL blinker1_count got=%0d exp=%0d", plots.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < plots.size(); i++) begin
      checks++;
      if (plots[i] !== exp_q[i]) begin
        errors++; $display("FAIL blinker1_pix[%0d] got=%h exp=%h", i, plots[i], exp_q[i]);
      end
    end
    checks++;
    if (done_at - t0 != 55 || generation !== 16'd1) begin
      errors++; $display("FAIL blinker1_done got lat=%0d gen=%0d exp lat=55 gen=1", done_at - t0, generation);
    end
    exp_q.delete();
    exp_q.push_back(enc(2, 1, 0)); exp_q.push_back(enc(1, 2, 7));
    exp_q.push_back(enc(3, 2, 7)); exp_q.push_back(enc(2, 3, 0));
    start_step(); collect(300, 0, 1'b1, -1);
    checks++;
    if (plots.size() != exp_q.size()) begin
      errors++; $display("FAIL blinker2_count got=%0d exp=%0d", plots.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < plots.size(); i++) begin
      checks++;
      if (plots[i] !== exp_q[i]) begin
        errors++; $display("FAIL blinker2_pix[%0d] got=%h exp=%h", i, plots[i], exp_q[i]);
      end
    end
    checks++;
    if (done_at - t0 != 55 || generation !== 16'd2) begin
      errors++; $display("FAIL blinker2_done got lat=%0d gen=%0d exp lat=55 gen=2", done_at - t0, generation);
    end
  endtask

  task automatic test_still_life();
    do_reset();
    do_load(0, 0, 1'b1); do_load(1, 0, 1'b1); do_load(0, 1, 1'b1); do_load(1, 1, 1'b1);
    start_step(); collect(300, 0, 1'b1, -1);
    checks++;
    if (plots.size() != 0 || done_at - t0 != 51 || generation !== 16'd1) begin
      errors++;
      $display("FAIL still_life got plots=%0d lat=%0d gen=%0d exp plots=0 lat=51 gen=1",
               plots.size(), done_at - t0, generation);
    end
  endtask

  task automatic test_torus();
    logic [18:0] exp_q[$];
    int exp_lat;
    do_reset();
    do_load(0, 1, 1'b1); do_load(0, 2, 1'b1); do_load(0, 3, 1'b1);
    exp_q.push_back(enc(0, 1, 0)); exp_q.push_back(enc(1, 2, 7));
`ifdef LIFE_TORUS_EN
    exp_q.push_back(enc(4, 2, 7));
`endif
    exp_q.push_back(enc(0, 3, 0));
    exp_lat = 2 * 25 + exp_q.size() + 1;
    start_step(); collect(300, 0, 1'b1, -1);
    checks++;
    if (plots.size() != exp_q.size()) begin
      errors++; $display("FAIL edge_count got=%0d exp=%0d", plots.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < plots.size(); i++) begin
      checks++;
      if (plots[i] !== exp_q[i]) begin
        errors++; $display("FAIL edge_pix[%0d] got=%h exp=%h", i, plots[i], exp_q[i]);
      end
    end
    checks++;
    if (done_at - t0 != exp_lat) begin
      errors++; $display("FAIL edge_latency got=%0d exp=%0d", done_at - t0, exp_lat);
    end
  endtask

  task automatic test_back_pressure();
    logic [18:0] exp_q[$];
    do_reset();
    load_blinker_h();
    exp_q.push_back(enc(2, 1, 7)); exp_q.push_back(enc(1, 2, 0));
    exp_q.push_back(enc(3, 2, 0)); exp_q.push_back(enc(2, 3, 7));
    start_step(); collect(400, 5, 1'b1, -1);
    checks++;
    if (plots.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_count got=%0d exp=%0d", plots.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < plots.size(); i++) begin
      checks++;
      if (plots[i] !== exp_q[i] || holds[i] != 6) begin
        errors++;
        $display("FAIL bp_pix[%0d] got=%h hold=%0d exp=%h hold=6", i, plots[i], holds[i], exp_q[i]);
      end
    end
    checks++;
    if (done_at - t0 != 75) begin
      errors++; $display("FAIL bp_latency got=%0d exp=75", done_at - t0);
    end
    plot_ready = 1'b1;
  endtask

  task automatic test_clear();
    logic [18:0] exp_q[$];
    exp_q.push_back(enc(2, 1, 0)); exp_q.push_back(enc(2, 2, 0)); exp_q.push_back(enc(2, 3, 0));
    @(negedge clock); clear = 1'b1; plot_ready = 1'b1; t0 = cyc;
    collect(300, 0, 1'b1, -1);
    checks++;
    if (plots.size() != exp_q.size()) begin
      errors++; $display("FAIL clear_count got=%0d exp=%0d", plots.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < plots.size(); i++) begin
      checks++;
      if (plots[i] !== exp_q[i]) begin
        errors++; $display("FAIL clear_pix[%0d] got=%h exp=%h", i, plots[i], exp_q[i]);
      end
    end
    checks++;
    if (done_at - t0 != 29 || generation !== 16'd0) begin
      errors++; $display("FAIL clear_done got lat=%0d gen=%0d exp lat=29 gen=0", done_at - t0, generation);
    end
  endtask

  task automatic test_command_edges();
    do_reset();
    @(negedge clock); load = 1'b1; load_x = 8'd5; load_y = 8'd0; load_alive = 1'b1;
    @(negedge clock); load = 1'b0;
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL load_oob got plot=%b busy=%b exp 0 0", plot, busy);
    end
    @(negedge clock);
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL load_oob_hold got plot=%b busy=%b exp 0 0", plot, busy);
    end
    @(negedge clock);
    load = 1'b1; step = 1'b1; load_x = 8'd1; load_y = 8'd1; load_alive = 1'b1;
    @(negedge clock); load = 1'b0; step = 1'b0;
    checks++;
    if (!(plot === 1'b1 && busy === 1'b1 && {out_x, out_y, out_colour} === enc(1, 1, 7))) begin
      errors++;
      $display("FAIL load_step_plot got plot=%b busy=%b pix=%h exp 1 1 %h", plot, busy,
               {out_x, out_y, out_colour}, enc(1, 1, 7));
    end
    collect(12, 0, 1'b0, -1);
    checks++;
    if (busy !== 1'b0 || ndone != 0 || plots.size() != 0 || generation !== 16'd0) begin
      errors++;
      $display("FAIL load_step_only_load got busy=%b dones=%0d plots=%0d gen=%0d exp 0 0 0 0",
               busy, ndone, plots.size(), generation);
    end
    start_step(); collect(300, 0, 1'b1, 10);
    checks++;
    if (plots.size() != 1 || done_at - t0 != 52) begin
      errors++; $display("FAIL busy_step got plots=%0d lat=%0d exp plots=1 lat=52", plots.size(), done_at - t0);
    end else begin
      checks++;
      if (plots[0] !== enc(1, 1, 0)) begin
        errors++; $display("FAIL busy_step_pix got=%h exp=%h", plots[0], enc(1, 1, 0));
      end
    end
    collect(80, 0, 1'b0, -1);
    checks++;
    if (ndone != 0 || generation !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_step_ignored got dones=%0d gen=%0d busy=%b exp 0 1 0", ndone, generation, busy);
    end
  endtask

  task automatic test_reset_mid_draw();
    do_reset();
    load_blinker_h();
    start_step(); collect(40, 100, 1'b0, -1);
    checks++;
    if (plot !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_draw_pending got plot=%b busy=%b exp 1 1", plot, busy);
    end
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, plot} !== 3'b000 || {out_x, out_y, out_colour} !== 19'd0 || generation !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got busy=%b done=%b plot=%b pix=%h gen=%0d exp all 0",
               busy, done, plot, {out_x, out_y, out_colour}, generation);
    end
    reset = 1'b0; plot_ready = 1'b1;
    collect(80, 0, 1'b0, -1);
    checks++;
    if (ndone != 0 || plots.size() != 0) begin
      errors++; $display("FAIL mid_reset_quiet got dones=%0d plots=%0d exp 0 0", ndone, plots.size());
    end
    start_step(); collect(300, 0, 1'b1, -1);
    checks++;
    if (plots.size() != 0 || done_at - t0 != 51 || generation !== 16'd1) begin
      errors++;
      $display("FAIL mid_reset_grid_dead got plots=%0d lat=%0d gen=%0d exp 0 51 1",
               plots.size(), done_at - t0, generation);
    end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_still_life();
    test_torus();
    test_back_pressure();
    test_clear();
    test_command_edges();
    test_reset_mid_draw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
